// File: rtl/dram_port_arb_pkg.sv
// Shared definitions for the dram0 port arbiter: FSM encoding, default widths
// and the round-robin pointer advance.
package dram_port_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam int DRAM_ADDR_WIDTH = 28;
  localparam int DRAM_DATA_WIDTH = 32;
  localparam logic [DRAM_DATA_WIDTH-1:0] TIMEOUT_DATA = '0;

  // Pointer moves just past the requester that was served, wrapping at n.
  function automatic logic [2:0] next_ptr(input logic [2:0] g, input int n);
    return (int'(g) == n - 1) ? 3'd0 : g + 3'd1;
  endfunction

endpackage

// File: rtl/dram_port_arb_rr_pick.sv
// Combinational round-robin selector: lowest pending index at or above ptr,
// otherwise the lowest pending index overall.
module dram_port_arb_rr_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0] pending,
  input  logic [2:0]   ptr,
  output logic [2:0]   grant,
  output logic         any
);

  logic [2:0] hi_idx;
  logic [2:0] lo_idx;
  logic       hi_ok;

  always_comb begin
    hi_idx = '0;
    lo_idx = '0;
    hi_ok  = 1'b0;
    // Scan downward so the lowest qualifying index is the one left standing.
    for (int i = N - 1; i >= 0; i--) begin
      if (pending[i]) begin
        lo_idx = 3'(i);
        if (3'(i) >= ptr) begin
          hi_idx = 3'(i);
          hi_ok  = 1'b1;
        end
      end
    end
    grant = hi_ok ? hi_idx : lo_idx;
    any   = |pending;
  end

endmodule

// File: rtl/dram_port_arb.sv
// Shares the single dram0 peek/poke port among NUM_REQ single-word requesters,
// with round-robin grant and a timeout against a hung DRAM controller.
module dram_port_arb
  import dram_port_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = DRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = DRAM_DATA_WIDTH,
  parameter int TIMEOUT    = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]            req_we_i,
  input  logic [NUM_REQ-1:0]            req_pop_i,
  output logic [NUM_REQ-1:0]            req_busy_o,
  output logic [NUM_REQ-1:0]            req_ack_o,
  output logic [NUM_REQ-1:0]            req_err_o,
  output logic [DATA_WIDTH-1:0]         req_data_o,
  output logic [2:0]                    grant_o,
  output logic [ADDR_WIDTH-1:0]         dram_addr_o,
  output logic [DATA_WIDTH-1:0]         dram_data_o,
  output logic                          dram_we_o,
  output logic                          dram_pop_o,
  input  logic [DATA_WIDTH-1:0]         dram_data_i,
  input  logic                          dram_ack_i
);

  logic [NUM_REQ-1:0]    pending_reg;
  logic [NUM_REQ-1:0]    slot_we_reg;
  logic [ADDR_WIDTH-1:0] slot_addr_reg [NUM_REQ];
  logic [DATA_WIDTH-1:0] slot_data_reg [NUM_REQ];

  state_t                state_reg, state_next;
  logic [2:0]            rr_ptr_reg;
  logic [2:0]            grant_reg;
  logic [15:0]           cnt_reg;
  logic                  we_reg;
  logic [ADDR_WIDTH-1:0] dram_addr_reg;
  logic [DATA_WIDTH-1:0] dram_data_reg;
  logic [NUM_REQ-1:0]    ack_reg, err_reg;
  logic [DATA_WIDTH-1:0] rdata_reg;

  logic [2:0]            pick_idx;
  logic                  pick_any;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_we;
  logic                  expired, done;
  logic [NUM_REQ-1:0]    cap, clr, grant_hit;

  dram_port_arb_rr_pick #(.N(NUM_REQ)) u_pick (
    .pending (pending_reg),
    .ptr     (rr_ptr_reg),
    .grant   (pick_idx),
    .any     (pick_any)
  );

  // Abort on the edge where the wait counter would reach TIMEOUT.
  assign expired = (({1'b0, cnt_reg} + 17'd1) == 17'(TIMEOUT));
  assign done    = (state_reg == ST_WAIT) && (dram_ack_i || expired);

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slot
    assign cap[gi]       = !pending_reg[gi] && (req_we_i[gi] || req_pop_i[gi]);
    assign grant_hit[gi] = (grant_reg == 3'(gi));
    assign clr[gi]       = done && grant_hit[gi];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_reg <= '0;
      slot_we_reg <= '0;
      for (int k = 0; k < NUM_REQ; k++) begin
        slot_addr_reg[k] <= '0;
        slot_data_reg[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (cap[k]) begin
          pending_reg[k]   <= 1'b1;
          slot_we_reg[k]   <= req_we_i[k];
          slot_addr_reg[k] <= req_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
          slot_data_reg[k] <= req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
        end else if (clr[k]) begin
          pending_reg[k] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    sel_we   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick_idx == 3'(k)) begin
        sel_addr = slot_addr_reg[k];
        sel_data = slot_data_reg[k];
        sel_we   = slot_we_reg[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (pick_any) state_next = ST_ISSUE;
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT:  if (done) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    dram_we_o  = (state_reg == ST_ISSUE) && we_reg;
    dram_pop_o = (state_reg == ST_ISSUE) && !we_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_reg    <= '0;
      grant_reg     <= '0;
      cnt_reg       <= '0;
      we_reg        <= 1'b0;
      dram_addr_reg <= '0;
      dram_data_reg <= '0;
      ack_reg       <= '0;
      err_reg       <= '0;
      rdata_reg     <= '0;
    end else begin
      ack_reg <= '0;
      err_reg <= '0;
      case (state_reg)
        ST_IDLE: if (pick_any) begin
          grant_reg     <= pick_idx;
          dram_addr_reg <= sel_addr;
          dram_data_reg <= sel_data;
          we_reg        <= sel_we;
        end
        ST_ISSUE: cnt_reg <= '0;
        ST_WAIT: begin
          cnt_reg <= cnt_reg + 16'd1;
          if (done) begin
            ack_reg    <= grant_hit;
            err_reg    <= dram_ack_i ? '0 : grant_hit;
            rr_ptr_reg <= next_ptr(grant_reg, NUM_REQ);
            if (!dram_ack_i)  rdata_reg <= DATA_WIDTH'(TIMEOUT_DATA);
            else if (!we_reg) rdata_reg <= dram_data_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_busy_o  = pending_reg;
  assign req_ack_o   = ack_reg;
  assign req_err_o   = err_reg;
  assign req_data_o  = rdata_reg;
  assign grant_o     = grant_reg;
  assign dram_addr_o = dram_addr_reg;
  assign dram_data_o = dram_data_reg;

endmodule

// File: tb/tb_dram_port_arb.sv
// Directed bench for dram_port_arb: reads, writes, contention, busy drop,
// timeout and reset mid-access, with hand-computed expectations.
module tb_dram_port_arb;

  localparam int NR = 2;
  localparam int AW = 28;
  localparam int DW = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NR*AW-1:0] req_addr_i = '0;
  logic [NR*DW-1:0] req_data_i = '0;
  logic [NR-1:0]    req_we_i = '0;
  logic [NR-1:0]    req_pop_i = '0;
  logic [NR-1:0]    req_busy_o, req_ack_o, req_err_o;
  logic [DW-1:0]    req_data_o;
  logic [2:0]       grant_o;
  logic [AW-1:0]    dram_addr_o;
  logic [DW-1:0]    dram_data_o;
  logic             dram_we_o, dram_pop_o;
  logic [DW-1:0]    dram_data_i = '0;
  logic             dram_ack_i = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dram_port_arb #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_addr_i  (req_addr_i),
    .req_data_i  (req_data_i),
    .req_we_i    (req_we_i),
    .req_pop_i   (req_pop_i),
    .req_busy_o  (req_busy_o),
    .req_ack_o   (req_ack_o),
    .req_err_o   (req_err_o),
    .req_data_o  (req_data_o),
    .grant_o     (grant_o),
    .dram_addr_o (dram_addr_o),
    .dram_data_o (dram_data_o),
    .dram_we_o   (dram_we_o),
    .dram_pop_o  (dram_pop_o),
    .dram_data_i (dram_data_i),
    .dram_ack_i  (dram_ack_i)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int k, input logic we, input logic pop,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr_i[k*AW +: AW] = a;
    req_data_i[k*DW +: DW] = d;
    req_we_i[k]  = we;
    req_pop_i[k] = pop;
  endtask

  // Called at the negedge where the strobe was driven (or the previous ack cycle).
  task automatic serve(input int g, input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input int exp_wait, input int lat,
                       input logic [DW-1:0] rdata, input logic [DW-1:0] exp_rd);
    int n;
    @(negedge clk);
    req_we_i  = '0;
    req_pop_i = '0;
    chk("busy_set", 64'(req_busy_o[g]), 64'd1);
    n = 1;
    while (!(dram_we_o || dram_pop_o) && n < 12) begin
      @(negedge clk);
      n++;
    end
    chk("issue_seen", 64'(dram_we_o | dram_pop_o), 64'd1);
    chk("issue_lat", 64'(n), 64'(exp_wait));
    chk("grant", 64'(grant_o), 64'(g));
    chk("dram_we", 64'(dram_we_o), 64'(we));
    chk("dram_pop", 64'(dram_pop_o), 64'(!we));
    chk("dram_addr", 64'(dram_addr_o), 64'(addr));
    if (we) chk("dram_wdata", 64'(dram_data_o), 64'(wdata));
    repeat (lat) @(negedge clk);
    dram_ack_i  = 1'b1;
    dram_data_i = rdata;
    @(negedge clk);
    dram_ack_i  = 1'b0;
    dram_data_i = '0;
    chk("req_ack", 64'(req_ack_o), 64'(1 << g));
    chk("req_err", 64'(req_err_o), 64'd0);
    chk("req_data", 64'(req_data_o), 64'(exp_rd));
    chk("busy_clr", 64'(req_busy_o[g]), 64'd0);
    $display("txn req%0d %s addr=%07h rdata=%08h", g, we ? "write" : "read ", addr, req_data_o);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 64'(req_busy_o), 64'd0);
    chk("rst_ack", 64'(req_ack_o), 64'd0);
    chk("rst_err", 64'(req_err_o), 64'd0);
    chk("rst_data", 64'(req_data_o), 64'd0);
    chk("rst_grant", 64'(grant_o), 64'd0);
    chk("rst_dram", 64'({dram_we_o, dram_pop_o, dram_addr_o}), 64'd0);
    @(negedge clk);

    // Single read, ack 3 cycles after the downstream strobe.
    set_req(0, 1'b0, 1'b1, 28'h0000100, 32'h0);
    serve(0, 1'b0, 28'h0000100, 32'h0, 2, 3, 32'hCAFEBABE, 32'hCAFEBABE);

    // Single write from req1; read data register must hold.
    set_req(1, 1'b1, 1'b0, 28'h0ABCDEF, 32'h12345678);
    serve(1, 1'b1, 28'h0ABCDEF, 32'h12345678, 2, 1, 32'hDEADBEEF, 32'hCAFEBABE);

    // Simultaneous pair with rr_ptr=0: 0 then 1.
    set_req(0, 1'b0, 1'b1, 28'h0000010, 32'h0);
    set_req(1, 1'b1, 1'b0, 28'h0000020, 32'hA5A5A5A5);
    serve(0, 1'b0, 28'h0000010, 32'h0, 2, 1, 32'h11111111, 32'h11111111);
    serve(1, 1'b1, 28'h0000020, 32'hA5A5A5A5, 1, 2, 32'hBAD0BAD0, 32'h11111111);

    // Re-strobe while busy is dropped; re-strobe in the ack cycle is taken.
    set_req(0, 1'b0, 1'b1, 28'h0000200, 32'h0);
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, 28'h0000333, 32'hFFFFFFFF);
    serve(0, 1'b0, 28'h0000200, 32'h0, 1, 1, 32'h22222222, 32'h22222222);
    set_req(0, 1'b1, 1'b0, 28'h0000444, 32'h55AA55AA);
    serve(0, 1'b1, 28'h0000444, 32'h55AA55AA, 2, 1, 32'hBAD0BAD0, 32'h22222222);

    // rr_ptr now 1: simultaneous pair is served 1 then 0.
    set_req(0, 1'b0, 1'b1, 28'h0000030, 32'h0);
    set_req(1, 1'b0, 1'b1, 28'h0000040, 32'h0);
    serve(1, 1'b0, 28'h0000040, 32'h0, 2, 1, 32'h33333333, 32'h33333333);
    serve(0, 1'b0, 28'h0000030, 32'h0, 1, 1, 32'h44444444, 32'h44444444);

    // Timeout: no ack, completion with err 9 cycles after the strobe downstream.
    set_req(0, 1'b0, 1'b1, 28'h0000777, 32'h0);
    @(negedge clk);
    req_pop_i = '0;
    @(negedge clk);
    chk("to_pop", 64'(dram_pop_o), 64'd1);
    chk("to_addr", 64'(dram_addr_o), 64'h777);
    for (int i = 3; i <= 10; i++) begin
      @(negedge clk);
      chk("to_noack", 64'(req_ack_o), 64'd0);
    end
    @(negedge clk);
    chk("to_ack", 64'(req_ack_o), 64'd1);
    chk("to_err", 64'(req_err_o), 64'd1);
    chk("to_data", 64'(req_data_o), 64'd0);
    chk("to_busy", 64'(req_busy_o), 64'd0);
    $display("txn req0 read  addr=0000777 timed out");
    @(negedge clk);
    @(negedge clk);
    dram_ack_i  = 1'b1;
    dram_data_i = 32'h99999999;
    @(negedge clk);
    dram_ack_i = 1'b0;
    chk("late_ack1", 64'(req_ack_o), 64'd0);
    @(negedge clk);
    chk("late_ack2", 64'(req_ack_o), 64'd0);
    chk("late_data", 64'(req_data_o), 64'd0);

    // Reset during WAIT with both requesters pending (req1 granted).
    set_req(0, 1'b0, 1'b1, 28'h0000050, 32'h0);
    set_req(1, 1'b0, 1'b1, 28'h0000060, 32'h0);
    @(negedge clk);
    req_pop_i = '0;
    @(negedge clk);
    chk("rw_grant", 64'(grant_o), 64'd1);
    chk("rw_pop", 64'(dram_pop_o), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rw_busy", 64'(req_busy_o), 64'd0);
    chk("rw_ack", 64'(req_ack_o), 64'd0);
    chk("rw_grant0", 64'(grant_o), 64'd0);
    dram_ack_i  = 1'b1;
    dram_data_i = 32'h88888888;
    @(negedge clk);
    dram_ack_i = 1'b0;
    chk("rw_stray_ack", 64'(req_ack_o), 64'd0);
    chk("rw_stray_data", 64'(req_data_o), 64'd0);
    @(negedge clk);
    chk("rw_idle", 64'({dram_we_o, dram_pop_o, req_busy_o}), 64'd0);
    $display("txn reset mid-wait, pending dropped");

    // After reset rr_ptr is 0 again.
    set_req(0, 1'b0, 1'b1, 28'h0000070, 32'h0);
    set_req(1, 1'b0, 1'b1, 28'h0000080, 32'h0);
    serve(0, 1'b0, 28'h0000070, 32'h0, 2, 1, 32'h66666666, 32'h66666666);
    serve(1, 1'b0, 28'h0000080, 32'h0, 1, 1, 32'h77777777, 32'h77777777);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dram_port_arb.md
Name: dram_port_arb

Overview:
- Shares the single dram0 peek/poke port among NUM_REQ requesters, e.g. the SPI CSR bridge (index 0) and the NKMD debug/DMA path (index 1).
- Each requester issues single-word reads or writes with one-cycle strobes.
- The arbiter latches them, grants round-robin, issues one downstream access at a time and returns a per-requester ack, with timeout protection against a hung DRAM controller.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- ADDR_WIDTH, 28, DRAM word address width
- DATA_WIDTH, 32, data width
- TIMEOUT, 255, max cycles to wait for dram_ack_i before aborting (1..65535)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_addr_i  in  NUM_REQ*ADDR_WIDTH  flattened per-requester address, slot k at [k*ADDR_WIDTH +: ADDR_WIDTH]
- req_data_i  in  NUM_REQ*DATA_WIDTH  flattened per-requester write data
- req_we_i  in  NUM_REQ  one-cycle write strobe
- req_pop_i  in  NUM_REQ  one-cycle read strobe
- req_busy_o  out  NUM_REQ  request pending for that requester
- req_ack_o  out  NUM_REQ  one-cycle completion pulse
- req_err_o  out  NUM_REQ  qualifies req_ack_o: access timed out
- req_data_o  out  DATA_WIDTH  read data (shared), valid while req_ack_o[k]
- grant_o  out  3  index of the current/last granted requester
- dram_addr_o  out  ADDR_WIDTH  downstream address
- dram_data_o  out  DATA_WIDTH  downstream write data
- dram_we_o  out  1  one-cycle write strobe
- dram_pop_o  out  1  one-cycle read strobe
- dram_data_i  in  DATA_WIDTH  read data
- dram_ack_i  in  1  completion pulse (reads and writes)

Behaviour:
- Reset values:
  - All outputs 0, pending/slot registers cleared.
  - rr_ptr=0, state=IDLE, timeout counter=0.
- Capture:
  - Strobe at cycle T while req_busy_o[k]=0 latches addr, data and we into slot k.
  - We and pop both high is treated as a write.
  - req_busy_o[k]=1 from T+1.
  - Strobes while busy are ignored; the slot is not modified.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - If any slot is pending, grant the first pending index searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - Register grant_o and the slot contents into the downstream regs, then go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (exactly 1 cycle):
  - dram_we_o or dram_pop_o=1 per the latched we.
  - dram_addr_o/dram_data_o hold the slot values.
  - Clear counter, go to WAIT.
  - dram_addr_o/dram_data_o stay stable until the next ISSUE.
- WAIT:
  - Counter increments each cycle.
  - On dram_ack_i, the next cycle has req_ack_o[g]=1 and req_err_o[g]=0.
  - For reads, req_data_o<=dram_data_i; for writes, req_data_o holds its previous value.
  - Pending[g] is cleared on the same edge, so req_busy_o[g] falls while req_ack_o is high.
  - rr_ptr<=(g+1) mod NUM_REQ; go to IDLE.
- Timeout: counter==TIMEOUT with no ack gives the same completion, but req_err_o[g]=1 and req_data_o=0.
- Latency: strobe at T, arbitrate at T+1, downstream strobe at T+2. With ack at T+2+L (L>=1), req_ack_o is at T+3+L.
- Simultaneous events:
  - A strobe from requester g in its own req_ack_o cycle is accepted (busy already low).
  - Strobes from several requesters in one cycle are all latched.
  - The ack and a new capture in the same cycle are independent.
- Stray acks: dram_ack_i in IDLE or ISSUE is ignored. A late ack arriving after a timeout is therefore ignored, because the arbiter is back in IDLE.
- Fairness: with all requesters continuously pending, grants rotate 0,1,..,NUM_REQ-1. The worst-case wait is (NUM_REQ-1) accesses.
- Reset mid-operation: pending requests are dropped without an ack, and any downstream access in flight is abandoned. Requesters must treat rst as aborting.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE/ST_ISSUE/ST_WAIT
  - DRAM_ADDR_WIDTH=28, DRAM_DATA_WIDTH=32
  - TIMEOUT_DATA=0
- One natural sub-module: rr_pick, a combinational round-robin priority selector (pending vector, rr_ptr -> grant index, any).
- Slot registers and the FSM stay in dram_port_arb.

Test Plan:
- Single read: req0 pop addr=0x0000100, ack after 3 cycles with data 0xCAFEBABE -> dram_pop_o pulse at T+2 with addr 0x0000100; req_ack_o=01, req_data_o=0xCAFEBABE at T+6; busy0 low.
- Single write: req1 we addr=0x0ABCDEF, data=0x12345678 -> dram_we_o one cycle with those values; req_ack_o=10, err=0; req_data_o unchanged.
- Contention: req0 and req1 strobe the same cycle with rr_ptr=0 -> req0 is served first, then req1; the next simultaneous pair is served 1 then 0.
- Timeout: TIMEOUT=8, no dram_ack_i -> req_ack_o[0] and req_err_o[0] high 9 cycles after ISSUE, req_data_o=0. An ack injected 2 cycles later produces no req_ack_o.
- Busy drop: a second strobe from req0 while busy with a different addr -> only the first address is seen downstream. A re-strobe in the req_ack_o cycle is accepted and issued.
- Reset mid-WAIT: rst during WAIT with req1 pending -> all busy=0, no acks, state IDLE; an ack arriving after reset is ignored.
